// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 receive path.
// Holds the receiver state encoding, the pixel word size and the default pulse
// timing at 50 MHz. The transmitter uses the same timing constants, so loopback
// thresholds cannot drift apart.
package ws2812_pkg;

  typedef enum logic [1:0] {
    StResync,
    StIdle,
    StHigh,
    StLow
  } rx_state_e;

  localparam int unsigned BITS_PER_PIXEL = 24;

  // Default pulse timing in clk cycles at 50 MHz
  localparam int unsigned T_MIN_HIGH_DEFAULT = 5;
  localparam int unsigned T_THRESH_DEFAULT   = 30;
  localparam int unsigned T_MAX_HIGH_DEFAULT = 60;
  localparam int unsigned T_RESET_DEFAULT    = 2500;

endpackage

// File: rtl/ws2812_sync.sv
// Input conditioning for the WS2812 serial line.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   din       - asynchronous serial input
//   din_s     - din after a 2-flop synchronizer
//   rise/fall - din_s differs from its one-cycle-delayed copy
// The synchronizer resets to 0, the idle level of the line.
module ws2812_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic din_s_q;
  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      din_s_q <= 1'b0;
      din_q   <= 1'b0;
    end else begin
      meta_q  <= din;
      din_s_q <= meta_q;
      din_q   <= din_s_q;
    end
  end

  assign din_s = din_s_q;
  assign rise  = din_s_q & ~din_q;
  assign fall  = ~din_s_q & din_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ stream receiver.
// Measures the width of every high pulse on the line, classifies it as a 0 or a
// 1 bit, assembles 24-bit GRB pixel words and reports frame boundaries when the
// line stays low for T_RESET cycles.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   din         - asynchronous serial input
//   pixel_data  - last complete pixel, GRB, first received bit in the MSB
//   pixel_valid - one-cycle pulse when pixel_data updates
//   pixel_idx   - index of pixel_data within the current frame (saturating)
//   frame_end   - one-cycle pulse when a reset latch ends a frame
//   err         - one-cycle pulse on a malformed pulse or truncated pixel
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned T_MIN_HIGH = T_MIN_HIGH_DEFAULT,
  parameter int unsigned T_THRESH   = T_THRESH_DEFAULT,
  parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_DEFAULT,
  parameter int unsigned T_RESET    = T_RESET_DEFAULT,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  output logic [IDX_W-1:0]          pixel_idx,
  output logic                      frame_end,
  output logic                      err
);

  localparam int unsigned CNT_W     = $clog2(T_RESET + 1);
  localparam int unsigned BIT_CNT_W = $clog2(BITS_PER_PIXEL);

  localparam logic [CNT_W-1:0]     CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CntMinHigh = CNT_W'(T_MIN_HIGH);
  localparam logic [CNT_W-1:0]     CntThresh  = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0]     CntMaxHigh = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0]     CntReset   = CNT_W'(T_RESET);
  localparam logic [BIT_CNT_W-1:0] LastBit    = BIT_CNT_W'(BITS_PER_PIXEL - 1);
  localparam logic [BIT_CNT_W-1:0] BitCntOne  = BIT_CNT_W'(1);
  localparam logic [IDX_W-1:0]     PixCntOne  = IDX_W'(1);

  logic din_s;
  logic rise;
  logic fall;

  ws2812_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_e                 state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [BIT_CNT_W-1:0]      bit_cnt_q;
  logic [BITS_PER_PIXEL-1:0] shift_q;
  logic [IDX_W-1:0]          pix_cnt_q;
  // Set on the cycle the 24th bit is shifted in; the word is published one
  // cycle later through the output registers.
  logic                      word_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StResync;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pix_cnt_q   <= '0;
      word_done_q <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_idx   <= '0;
      frame_end   <= 1'b0;
      err         <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      err         <= 1'b0;
      word_done_q <= 1'b0;

      if (word_done_q) begin
        pixel_data  <= shift_q;
        pixel_valid <= 1'b1;
        pixel_idx   <= pix_cnt_q;
        if (pix_cnt_q != '1) begin
          pix_cnt_q <= pix_cnt_q + PixCntOne;
        end
      end

      case (state_q)
        // Wait for a full latch-length low before trusting any pulse.
        StResync: begin
          if (cnt_q == CntReset) begin
            // A rise landing on the latch cycle is the first bit of a frame.
            if (rise) begin
              state_q <= StHigh;
              cnt_q   <= CntOne;
            end else begin
              state_q <= StIdle;
            end
          end else if (din_s) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StIdle: begin
          if (rise) begin
            state_q <= StHigh;
            cnt_q   <= CntOne;
          end
        end

        // cnt_q holds the number of high cycles seen so far.
        StHigh: begin
          if (cnt_q == CntMaxHigh) begin
            err       <= 1'b1;
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
            cnt_q     <= '0;
            state_q   <= StResync;
          end else if (fall) begin
            if (cnt_q < CntMinHigh) begin
              err       <= 1'b1;
              bit_cnt_q <= '0;
              pix_cnt_q <= '0;
              cnt_q     <= '0;
              state_q   <= StResync;
            end else begin
              shift_q <= {shift_q[BITS_PER_PIXEL-2:0], (cnt_q >= CntThresh)};
              if (bit_cnt_q == LastBit) begin
                bit_cnt_q   <= '0;
                word_done_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + BitCntOne;
              end
              cnt_q   <= CntOne;
              state_q <= StLow;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        // cnt_q holds the number of low cycles since the last falling edge.
        StLow: begin
          if (cnt_q == CntReset) begin
            frame_end <= 1'b1;
            if (bit_cnt_q != '0) begin
              err <= 1'b1;
            end
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
            if (rise) begin
              state_q <= StHigh;
              cnt_q   <= CntOne;
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end else if (rise) begin
            state_q <= StHigh;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        default: begin
          state_q <= StResync;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx with a shortened latch time.
`timescale 1ns / 1ps
module tb_ws2812_rx;

  localparam int unsigned TReset = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_idx;
  logic        frame_end;
  logic        err;

  ws2812_rx #(
    .T_MIN_HIGH (5),
    .T_THRESH   (30),
    .T_MAX_HIGH (60),
    .T_RESET    (TReset),
    .IDX_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_idx   (pixel_idx),
    .frame_end   (frame_end),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observed events
  logic [23:0] pv_data[$];
  logic [7:0]  pv_idx[$];
  int          pv_cyc[$];
  int          fe_cyc[$];
  int          err_cyc[$];
  int          overlap = 0;

  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_data.push_back(pixel_data);
      pv_idx.push_back(pixel_idx);
      pv_cyc.push_back(cyc);
    end
    if (frame_end) fe_cyc.push_back(cyc);
    if (err) err_cyc.push_back(cyc);
    if (pixel_valid && err) overlap++;
  end

  // Reference model: pixels expected from the words sent, and when
  logic [23:0] exp_words[$];
  int          exp_cyc[$];
  logic [23:0] last_word = 24'h0;
  int          last_fall = 0;
  bit          rand_timing = 1'b0;

  typedef struct {
    int unsigned high_w;
    logic        exp_bit;
    logic        exp_err;
  } thr_vec_t;

  thr_vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    din = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input int h, input int l);
    hold(1'b1, h);
    last_fall = cyc;
    hold(1'b0, l);
  endtask

  task automatic send_bit(input logic b);
    int h;
    int l;
    if (rand_timing) begin
      h = b ? int'($urandom_range(59, 30)) : int'($urandom_range(29, 5));
      l = int'($urandom_range(40, 5));
    end else begin
      h = b ? 40 : 20;
      l = b ? 22 : 42;
    end
    send_pulse(h, l);
  endtask

  // Send the first n bits of w, MSB first; optionally expect it as a pixel.
  task automatic send_word(input logic [23:0] w, input int n, input bit expect_pix);
    for (int i = 0; i < n; i++) send_bit(w[23-i]);
    if (expect_pix) begin
      exp_words.push_back(w);
      exp_cyc.push_back(last_fall + 4);
    end
  endtask

  task automatic check_frame(input string name, input int exp_fe, input int exp_err);
    check($sformatf("%s pixel count", name), 64'(pv_data.size()), 64'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < pv_data.size(); i++) begin
      check($sformatf("%s data[%0d]", name, i), 64'(pv_data[i]), 64'(exp_words[i]));
      check($sformatf("%s idx[%0d]", name, i), 64'(pv_idx[i]), 64'(i));
      check($sformatf("%s latency[%0d]", name, i), 64'(pv_cyc[i]), 64'(exp_cyc[i]));
    end
    check($sformatf("%s frame_end count", name), 64'(fe_cyc.size()), 64'(exp_fe));
    check($sformatf("%s err count", name), 64'(err_cyc.size()), 64'(exp_err));
    if (exp_words.size() > 0) last_word = exp_words[exp_words.size()-1];
    pv_data.delete();
    pv_idx.delete();
    pv_cyc.delete();
    fe_cyc.delete();
    err_cyc.delete();
    exp_words.delete();
    exp_cyc.delete();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_c;
    vecs[0] = '{5,  1'b0, 1'b0};
    vecs[1] = '{29, 1'b0, 1'b0};
    vecs[2] = '{30, 1'b1, 1'b0};
    vecs[3] = '{59, 1'b1, 1'b0};
    vecs[4] = '{4,  1'b0, 1'b1};
    vecs[5] = '{3,  1'b0, 1'b1};
    vecs[6] = '{60, 1'b0, 1'b1};

    rst = 1'b1;
    din = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset outputs during rst", {pixel_data, pixel_valid, pixel_idx, frame_end, err}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs after rst", {pixel_data, pixel_valid, pixel_idx, frame_end, err}, '0);
    @(posedge clk);
    #1;

    // Single pixel with exact latency of pixel_valid and frame_end
    hold(1'b0, TReset);
    send_word(24'hFF0080, 24, 1'b1);
    hold(1'b0, TReset + 10);
    if (fe_cyc.size() > 0) check("single frame_end latency", 64'(fe_cyc[0] - last_fall), 64'd203);
    check_frame("single", 1, 0);

    // Three back-to-back pixels
    hold(1'b0, TReset + 10);
    send_word(24'h000001, 24, 1'b1);
    send_word(24'h800000, 24, 1'b1);
    send_word(24'h5A5A5A, 24, 1'b1);
    hold(1'b0, TReset + 10);
    check_frame("three", 1, 0);

    // Glitch mid-pixel: rest of the frame ignored until a full latch
    hold(1'b0, TReset + 10);
    send_word(24'hAAAAAA, 10, 1'b0);
    send_pulse(3, 42);
    send_word(24'h3C3C3C, 24, 1'b0);
    hold(1'b0, TReset + 10);
    send_word(24'h123456, 24, 1'b1);
    hold(1'b0, TReset + 10);
    check_frame("glitch", 1, 1);

    // Stuck high, then data without a preceding latch
    hold(1'b0, TReset + 10);
    send_word(24'h0F0F0F, 5, 1'b0);
    rise_c = cyc;
    hold(1'b1, 100);
    hold(1'b0, 42);
    if (err_cyc.size() > 0) check("stuck err latency", 64'(err_cyc[0] - rise_c), 64'd63);
    send_word(24'hABCDEF, 24, 1'b0);
    hold(1'b0, TReset + 10);
    check_frame("stuck", 0, 1);
    check("stuck pixel_data held", 64'(pixel_data), 64'(last_word));

    // Truncated pixel ended by a latch
    hold(1'b0, TReset + 10);
    send_word(24'h5A5A5A, 10, 1'b0);
    hold(1'b0, TReset + 10);
    if (fe_cyc.size() > 0 && err_cyc.size() > 0)
      check("partial err with frame_end", 64'(err_cyc[0]), 64'(fe_cyc[0]));
    check_frame("partial", 1, 1);
    check("partial pixel_data held", 64'(pixel_data), 64'(last_word));

    // Pulse-width classification at the boundaries, as the last bit of a word
    for (int v = 0; v < 7; v++) begin
      hold(1'b0, TReset + 10);
      send_word(24'h000000, 23, 1'b0);
      send_pulse(int'(vecs[v].high_w), 42);
      if (!vecs[v].exp_err) begin
        exp_words.push_back({23'h0, vecs[v].exp_bit});
        exp_cyc.push_back(last_fall + 4);
      end
      hold(1'b0, TReset + 10);
      check_frame($sformatf("width %0d", vecs[v].high_w),
                  vecs[v].exp_err ? 0 : 1, vecs[v].exp_err ? 1 : 0);
      check($sformatf("width %0d pixel_data", vecs[v].high_w), 64'(pixel_data),
            64'(last_word));
    end

    // Random frames with random legal bit timing
    rand_timing = 1'b1;
    for (int f = 0; f < 5; f++) begin
      int n;
      hold(1'b0, TReset + 10);
      n = int'($urandom_range(3, 1));
      for (int p = 0; p < n; p++) begin
        logic [31:0] r;
        r = $urandom;
        send_word(r[23:0], 24, 1'b1);
      end
      hold(1'b0, TReset + 10);
      if (fe_cyc.size() > 0)
        check($sformatf("random %0d frame_end latency", f), 64'(fe_cyc[0] - last_fall), 64'd203);
      check_frame($sformatf("random %0d", f), 1, 0);
    end

    check("pixel_valid/err overlap", 64'(overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
